v_issue_queue: RTL and testbench
================================

Name: v_issue_queue

Overview:
- Instruction buffer and issue sequencer between the base processor and the vector coprocessor top level.
- Accepts 32-bit vector instructions from the base processor through a valid/ready handshake and buffers them in a FIFO.
- Drives exactly one instruction at a time onto the coprocessor instruction bus (op_instr_base) and holds it stable until the functional units signal completion.
- Retires vsetvli/vsetivli (vconfig) instructions in fixed time and guards every other instruction with a timeout.

Parameters:
- DEPTH, 4: FIFO entries; power of two, from 2 to 16.
- TIMEOUT, 64: maximum WAIT cycles before forced retire; range 2 to 255.
- IDLE_INSTR, 32'h0000_0000: value driven on op_instr while no instruction is issued.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous assert, active-low.
- instr_in  in  32  instruction from the base processor.
- instr_valid  in  1  instr_in is valid this cycle.
- instr_ready  out  1  queue can accept; equals (count != DEPTH), driven from registered state only.
- flush  in  1  synchronous clear of queue and in-flight instruction.
- unit_done  in  1  OR of done_valu, done_vmul, done_vred, done_vsldu and done_vlsu.
- op_instr  out  32  instruction presented to the coprocessor decoder.
- issue_valid  out  1  one-cycle pulse in the first cycle a new op_instr is presented.
- busy  out  1  high in ISSUE or WAIT.
- count  out  $clog2(DEPTH)+1  number of entries held, including the in-flight one.
- err_timeout  out  1  sticky; set on a forced retire, cleared only by reset.

Behaviour:
- Reset (nrst low, asynchronous) clears everything immediately, including mid-operation:
  - state = IDLE, pointers = 0, count = 0, op_instr = IDLE_INSTR, issue_valid = 0, busy = 0, err_timeout = 0, instr_ready = 1.
  - Instructions in flight are discarded.
- Push: occurs on a rising edge with instr_valid & instr_ready & !flush.
  - The write pointer increments modulo DEPTH (wrap-around).
  - The head entry is not popped until it retires; it remains counted while in flight.
- State machine (registered):
  - IDLE: if count != 0 → ISSUE. Otherwise op_instr = IDLE_INSTR.
  - ISSUE, exactly 1 cycle: op_instr = head entry, issue_valid = 1, timer loaded with 0.
    - If head is vconfig (opcode 7'b1010111, funct3 3'b111) → RETIRE.
    - Otherwise → WAIT.
  - WAIT: op_instr holds the head entry and the timer increments each cycle.
    - unit_done = 1 → RETIRE.
    - Timer reaches TIMEOUT-1 without unit_done → set err_timeout, then → RETIRE.
  - RETIRE, 1 cycle: op_instr = IDLE_INSTR, head popped (read pointer +1 mod DEPTH, count −1).
    - Next state is ISSUE if count after the pop is non-zero, else IDLE.
- unit_done outside WAIT is ignored. It must not pop or advance state.
- Latency:
  - A push into an empty, idle queue at edge N gives issue_valid high in cycle N+2 (IDLE sees count at N+1).
  - A vconfig instruction occupies op_instr for 1 cycle.
  - Back-to-back issue spacing is at least 3 cycles (ISSUE, WAIT, RETIRE), or 2 cycles for vconfig.
- Simultaneous push and RETIRE pop in the same cycle: count unchanged, both pointers advance.
- Full: instr_ready = 0 while count == DEPTH, even when a RETIRE occurs in the same cycle. There is no combinational ready path.
- Empty: the FSM stays in IDLE and op_instr = IDLE_INSTR.
- Flush (highest priority after reset):
  - Next cycle: state = IDLE, count = 0, pointers = 0, op_instr = IDLE_INSTR.
  - A push in the flush cycle is dropped.
  - A unit_done in the flush cycle is ignored.
  - err_timeout is retained.
- instr_in values are not checked. Non-vector opcodes are buffered and issued like any other instruction, and rely on the timeout if no unit responds.

Test Plan:
- Single instruction: push 32'h0220_8057 (vadd.vv) into an empty queue; pulse unit_done 4 cycles after issue_valid.
  - Required: issue_valid exactly once; op_instr stable for 5 cycles; then IDLE with count = 0.
- Fill (DEPTH = 4): push 5 instructions back-to-back with unit_done held low.
  - Required: instr_ready drops after the 4th accept; the 5th is held off; count = 4.
  - Then pulse unit_done: instr_ready returns high in the cycle after RETIRE.
- vconfig: push 32'h0C00_7057, then a vadd.
  - Required: the vconfig is on op_instr for 1 cycle with no unit_done needed; the vadd gets issue_valid 2 cycles after the vconfig's issue_valid.
- Timeout (TIMEOUT = 8): issue an instruction and never assert unit_done.
  - Required: err_timeout rises 8 cycles after issue_valid; the instruction retires; err_timeout stays high after a later normal instruction.
- Flush mid-WAIT with 3 entries queued, plus a push in the same cycle.
  - Required: next cycle count = 0, op_instr = 0, busy = 0; the pushed instruction is never issued.
- Asynchronous reset mid-WAIT: drop nrst between clock edges.
  - Required: op_instr = 0 and busy = 0 immediately, with no clock edge needed; pointer wrap is verified after 9 further push/retire pairs with correct FIFO order.

Source files
------------

// File: rtl/v_issue_queue.sv
// v_issue_queue: buffers vector instructions from the base processor and issues
// them one at a time to the coprocessor. The instruction is held until a unit
// completes it, vconfig instructions retire in fixed time, and a timeout forces
// retirement of anything that never completes.
module v_issue_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned TIMEOUT    = 64,
   parameter logic [31:0] IDLE_INSTR = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [31:0]            instr_in,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic                   flush,
   input  logic                   unit_done,
   output logic [31:0]            op_instr,
   output logic                   issue_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_timeout
);

   localparam int unsigned PW     = $clog2(DEPTH);
   localparam int unsigned CW     = PW + 1;
   localparam int unsigned TW     = 8;
   localparam logic [6:0]  OPC_V  = 7'b1010111;
   localparam logic [2:0]  F3_CFG = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RETIRE
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     mem [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [31:0]     head_d;
   logic [31:0]     op_instr_d;
   logic            issue_valid_d;
   logic            busy_d;
   logic            err_set;
   logic            push;
   logic            pop;
   logic            is_vcfg;

   // The issued instruction sits in op_instr during ISSUE, so decode it there
   assign is_vcfg = (op_instr[6:0] == OPC_V) && (op_instr[14:12] == F3_CFG);

   // Pointer/occupancy update; head_d is the entry that becomes head next cycle
   always_comb begin
      push     = instr_valid & instr_ready & ~flush;
      pop      = (state_q == S_RETIRE) & ~flush;
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count + CW'(push) - CW'(pop);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
      // An entry written in the same cycle it becomes head is bypassed from instr_in
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? instr_in : mem[rd_ptr_d];
   end

   // Next-state and next-output decode
   always_comb begin
      state_d       = state_q;
      err_set       = 1'b0;
      op_instr_d    = IDLE_INSTR;
      issue_valid_d = 1'b0;
      busy_d        = 1'b0;
      timer_d       = '0;

      case (state_q)
         S_IDLE: begin
            if (count != '0) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = is_vcfg ? S_RETIRE : S_WAIT;
         end
         S_WAIT: begin
            if (unit_done) begin
               state_d = S_RETIRE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_set = 1'b1;
               state_d = S_RETIRE;
            end
         end
         S_RETIRE: begin
            state_d = (count_d != '0) ? S_ISSUE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         state_d = S_IDLE;
         err_set = 1'b0;
      end

      case (state_d)
         S_ISSUE: begin
            op_instr_d    = head_d;
            issue_valid_d = 1'b1;
            busy_d        = 1'b1;
         end
         S_WAIT: begin
            op_instr_d = op_instr;
            busy_d     = 1'b1;
            timer_d    = timer_q + TW'(1);
         end
         default: ;
      endcase
   end

   // Instruction storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= instr_in;
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count       <= '0;
         timer_q     <= '0;
         op_instr    <= IDLE_INSTR;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         instr_ready <= 1'b1;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count       <= count_d;
         timer_q     <= timer_d;
         op_instr    <= op_instr_d;
         issue_valid <= issue_valid_d;
         busy        <= busy_d;
         err_timeout <= err_timeout | err_set;
         instr_ready <= (count_d != CW'(DEPTH));
      end
   end

endmodule

// File: tb/tb_v_issue_queue.sv
// Directed bench for v_issue_queue with DEPTH=4, TIMEOUT=8.
module tb_v_issue_queue;

   localparam logic [31:0] IDLE = 32'h0000_0000;
   localparam logic [31:0] VADD = 32'h0220_8057;
   localparam logic [31:0] VCFG = 32'h0C00_7057;

   logic        clk = 1'b0;
   logic        nrst;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic        flush;
   logic        unit_done;
   logic [31:0] op_instr;
   logic        issue_valid;
   logic        busy;
   logic [2:0]  count;
   logic        err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   v_issue_queue #(
      .DEPTH      (4),
      .TIMEOUT    (8),
      .IDLE_INSTR (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .flush       (flush),
      .unit_done   (unit_done),
      .op_instr    (op_instr),
      .issue_valid (issue_valid),
      .busy        (busy),
      .count       (count),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Safety net against a hung run
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [31:0] x);
      instr_in    = x;
      instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0;
   endtask

   // Wait (bounded) for the issue of exp, complete it in its first WAIT cycle
   task automatic serve(input logic [31:0] exp, input string tag);
      int n;
      n = 0;
      while (issue_valid !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk({tag, "_issue"}, 32'(issue_valid), 32'd1);
      chk({tag, "_op"}, op_instr, exp);
      cyc();
      unit_done = 1'b1;
      cyc();
      unit_done = 1'b0;
      chk({tag, "_retire_op"}, op_instr, IDLE);
   endtask

   function automatic logic [31:0] wv(input int i);
      return {4'hC, 4'(i), 24'h00_0057};
   endfunction

   initial begin
      int n_iv;
      nrst        = 1'b0;
      instr_in    = '0;
      instr_valid = 1'b0;
      flush       = 1'b0;
      unit_done   = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_op", op_instr, IDLE);
      chk("rst_iv", 32'(issue_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      nrst = 1'b1;
      cyc();

      // Single instruction, unit_done 4 cycles after issue
      push_one(VADD);
      chk("t1_count1", 32'(count), 32'd1);
      chk("t1_idle_iv", 32'(issue_valid), 32'd0);
      cyc();
      chk("t1_iv", 32'(issue_valid), 32'd1);
      chk("t1_op", op_instr, VADD);
      chk("t1_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk($sformatf("t1_wait%0d_iv", k), 32'(issue_valid), 32'd0);
         chk($sformatf("t1_wait%0d_op", k), op_instr, VADD);
      end
      unit_done = 1'b1;
      cyc();
      unit_done = 1'b0;
      chk("t1_retire_op", op_instr, IDLE);
      chk("t1_retire_busy", 32'(busy), 32'd0);
      cyc();
      chk("t1_end_count", 32'(count), 32'd0);
      chk("t1_end_op", op_instr, IDLE);

      // Fill to DEPTH, fifth held off until a retire frees a slot
      instr_valid = 1'b1;
      instr_in = 32'h1111_0057; cyc();
      instr_in = 32'h2222_0057; cyc();
      instr_in = 32'h3333_0057; cyc();
      chk("t2_count3", 32'(count), 32'd3);
      chk("t2_ready3", 32'(instr_ready), 32'd1);
      instr_in = 32'h4444_0057; cyc();
      chk("t2_count4", 32'(count), 32'd4);
      chk("t2_ready4", 32'(instr_ready), 32'd0);
      instr_in = 32'h5555_0057; cyc();
      chk("t2_held_count", 32'(count), 32'd4);
      chk("t2_held_ready", 32'(instr_ready), 32'd0);
      chk("t2_wait_op", op_instr, 32'h1111_0057);
      unit_done = 1'b1;
      cyc();
      unit_done = 1'b0;
      chk("t2_retire_ready", 32'(instr_ready), 32'd0);
      chk("t2_retire_op", op_instr, IDLE);
      cyc();
      chk("t2_after_ready", 32'(instr_ready), 32'd1);
      chk("t2_after_count", 32'(count), 32'd3);
      chk("t2_i2_iv", 32'(issue_valid), 32'd1);
      chk("t2_i2_op", op_instr, 32'h2222_0057);
      cyc();
      instr_valid = 1'b0;
      chk("t2_i5_count", 32'(count), 32'd4);
      unit_done = 1'b1;
      cyc();
      unit_done = 1'b0;
      chk("t2_i2_retire", op_instr, IDLE);
      serve(32'h3333_0057, "t2_i3");
      serve(32'h4444_0057, "t2_i4");
      serve(32'h5555_0057, "t2_i5");
      cyc();
      chk("t2_end_count", 32'(count), 32'd0);
      chk("t2_end_ready", 32'(instr_ready), 32'd1);

      // vconfig retires in fixed time; vadd pushed during its RETIRE
      push_one(VCFG);
      cyc();
      chk("t3_cfg_iv", 32'(issue_valid), 32'd1);
      chk("t3_cfg_op", op_instr, VCFG);
      cyc();
      chk("t3_cfg_retire_op", op_instr, IDLE);
      chk("t3_cfg_retire_iv", 32'(issue_valid), 32'd0);
      chk("t3_cfg_retire_count", 32'(count), 32'd1);
      push_one(VADD);
      chk("t3_pushpop_count", 32'(count), 32'd1);
      chk("t3_vadd_iv", 32'(issue_valid), 32'd1);
      chk("t3_vadd_op", op_instr, VADD);
      serve(VADD, "t3_vadd");
      cyc();
      chk("t3_end_count", 32'(count), 32'd0);

      // Timeout: no unit_done, forced retire 8 cycles after issue
      push_one(32'h7777_0057);
      cyc();
      chk("t4_iv", 32'(issue_valid), 32'd1);
      chk("t4_err0", 32'(err_timeout), 32'd0);
      for (int k = 1; k <= 7; k++) cyc();
      chk("t4_err_before", 32'(err_timeout), 32'd0);
      chk("t4_busy_before", 32'(busy), 32'd1);
      chk("t4_op_before", op_instr, 32'h7777_0057);
      cyc();
      chk("t4_err_set", 32'(err_timeout), 32'd1);
      chk("t4_retire_op", op_instr, IDLE);
      cyc();
      chk("t4_count", 32'(count), 32'd0);
      push_one(VADD);
      serve(VADD, "t4_norm");
      cyc();
      chk("t4_err_sticky", 32'(err_timeout), 32'd1);

      // Flush mid-WAIT with 3 entries plus a push and a unit_done in the same cycle
      instr_valid = 1'b1;
      instr_in = 32'h8888_0057; cyc();
      instr_in = 32'h8888_1057; cyc();
      instr_in = 32'h8888_2057; cyc();
      chk("t5_count3", 32'(count), 32'd3);
      chk("t5_busy", 32'(busy), 32'd1);
      instr_in  = 32'h9999_0057;
      flush     = 1'b1;
      unit_done = 1'b1;
      cyc();
      flush       = 1'b0;
      unit_done   = 1'b0;
      instr_valid = 1'b0;
      chk("t5_count0", 32'(count), 32'd0);
      chk("t5_op", op_instr, IDLE);
      chk("t5_busy0", 32'(busy), 32'd0);
      chk("t5_ready", 32'(instr_ready), 32'd1);
      chk("t5_err_kept", 32'(err_timeout), 32'd1);
      n_iv = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (issue_valid === 1'b1) n_iv++;
      end
      chk("t5_no_issue", 32'(n_iv), 32'd0);
      chk("t5_still_empty", 32'(count), 32'd0);

      // Asynchronous reset between edges mid-WAIT
      push_one(32'hAAAA_0057);
      cyc();
      cyc();
      chk("t6_wait_busy", 32'(busy), 32'd1);
      chk("t6_wait_op", op_instr, 32'hAAAA_0057);
      #2;
      nrst = 1'b0;
      #1;
      chk("t6_async_op", op_instr, IDLE);
      chk("t6_async_busy", 32'(busy), 32'd0);
      chk("t6_async_count", 32'(count), 32'd0);
      chk("t6_async_err", 32'(err_timeout), 32'd0);
      chk("t6_async_ready", 32'(instr_ready), 32'd1);
      #2;
      nrst = 1'b1;
      cyc();

      // Nine push/retire pairs in FIFO order, wrapping the pointers
      for (int p = 0; p < 4; p++) begin
         push_one(wv(2 * p));
         push_one(wv(2 * p + 1));
         serve(wv(2 * p), $sformatf("w%0d", 2 * p));
         serve(wv(2 * p + 1), $sformatf("w%0d", 2 * p + 1));
         cyc();
         chk($sformatf("w_pair%0d_count", p), 32'(count), 32'd0);
      end
      push_one(wv(8));
      serve(wv(8), "w8");
      cyc();
      chk("w_end_count", 32'(count), 32'd0);
      chk("w_end_op", op_instr, IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
